// File: rtl/stage_rr.sv
// Register-read stage: picks operands from the register array or in-flight results,
// detects load-use hazards and registers the instruction into the EX pipeline register.
module stage_rr #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [XLEN-1:0]             id_pc,
  input  logic [RW-1:0]               id_rs1,
  input  logic [RW-1:0]               id_rs2,
  input  logic                        id_use_rs1,
  input  logic                        id_use_rs2,
  input  logic [RW-1:0]               id_rd,
  input  logic                        id_w_rd,
  input  logic                        id_is_load,
  input  logic                        id_bubble,
  input  logic                        flush,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [RW-1:0]               ex_rd,
  input  logic                        ex_w_rd,
  input  logic                        ex_is_load,
  input  logic                        ex_bubble,
  input  logic [XLEN-1:0]             ex_res,
  input  logic [RW-1:0]               mem_rd,
  input  logic                        mem_w_rd,
  input  logic                        mem_bubble,
  input  logic [XLEN-1:0]             mem_res,
  input  logic [RW-1:0]               wb_rd,
  input  logic                        wb_w_rd,
  input  logic [XLEN-1:0]             wb_res,
  output logic                        stall,
  output logic [XLEN-1:0]             out_pc,
  output logic [XLEN-1:0]             out_a,
  output logic [XLEN-1:0]             out_b,
  output logic [RW-1:0]               out_rd,
  output logic                        out_w_rd,
  output logic                        out_is_load,
  output logic                        out_bubble
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            ex_load_live;
  logic            hazard;
  logic            insert_bubble;

  // A load sitting in EX has no data yet, so it is skipped here and covered by the stall.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [RW-1:0]               s,
    input logic [NREGS-1:0][XLEN-1:0]  rf,
    input logic [RW-1:0]               e_rd,
    input logic                        e_hit_ok,
    input logic [XLEN-1:0]             e_res,
    input logic [RW-1:0]               m_rd,
    input logic                        m_hit_ok,
    input logic [XLEN-1:0]             m_res,
    input logic [RW-1:0]               w_rd,
    input logic                        w_hit_ok,
    input logic [XLEN-1:0]             w_res
  );
    logic [XLEN-1:0] v;
    if (s == '0)                     v = '0;
    else if (e_hit_ok && e_rd == s)  v = e_res;
    else if (m_hit_ok && m_rd == s)  v = m_res;
    else if (w_hit_ok && w_rd == s)  v = w_res;
    else                             v = rf[s];
    return v;
  endfunction

  always_comb begin
    op_a = pick_operand(id_rs1, regs,
                        ex_rd, !ex_bubble && ex_w_rd && !ex_is_load, ex_res,
                        mem_rd, !mem_bubble && mem_w_rd, mem_res,
                        wb_rd, wb_w_rd, wb_res);
    op_b = pick_operand(id_rs2, regs,
                        ex_rd, !ex_bubble && ex_w_rd && !ex_is_load, ex_res,
                        mem_rd, !mem_bubble && mem_w_rd, mem_res,
                        wb_rd, wb_w_rd, wb_res);
  end

  always_comb begin
    ex_load_live  = !ex_bubble && ex_is_load && ex_w_rd && (ex_rd != '0);
    hazard        = !id_bubble && ex_load_live &&
                    ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    // Flush kills the decode slot, so the hazard no longer matters.
    stall         = hazard && !flush;
    insert_bubble = hazard || flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc      <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_rd      <= '0;
      out_w_rd    <= 1'b0;
      out_is_load <= 1'b0;
      out_bubble  <= 1'b1;
    end else begin
      out_pc <= id_pc;
      out_a  <= op_a;
      out_b  <= op_b;
      out_rd <= id_rd;
      if (insert_bubble) begin
        out_w_rd    <= 1'b0;
        out_is_load <= 1'b0;
        out_bubble  <= 1'b1;
      end else begin
        out_w_rd    <= id_w_rd && !id_bubble;
        out_is_load <= id_is_load && !id_bubble;
        out_bubble  <= id_bubble;
      end
    end
  end

endmodule

// File: tb/tb_stage_rr.sv
// Testbench for stage_rr: directed scenarios followed by randomized cycles checked
// against a producer-age reference model.
module tb_stage_rr;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         id_pc;
  logic [4:0]          id_rs1, id_rs2, id_rd;
  logic                id_use_rs1, id_use_rs2, id_w_rd, id_is_load, id_bubble;
  logic                flush;
  logic [31:0][31:0]   regs;
  logic [4:0]          ex_rd, mem_rd, wb_rd;
  logic                ex_w_rd, ex_is_load, ex_bubble;
  logic                mem_w_rd, mem_bubble, wb_w_rd;
  logic [31:0]         ex_res, mem_res, wb_res;
  logic                stall;
  logic [31:0]         out_pc, out_a, out_b;
  logic [4:0]          out_rd;
  logic                out_w_rd, out_is_load, out_bubble;

  int checks   = 0;
  int failures = 0;

  stage_rr dut (
    .clk(clk), .rst(rst),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_w_rd(id_w_rd), .id_is_load(id_is_load), .id_bubble(id_bubble),
    .flush(flush), .regs(regs),
    .ex_rd(ex_rd), .ex_w_rd(ex_w_rd), .ex_is_load(ex_is_load), .ex_bubble(ex_bubble),
    .ex_res(ex_res),
    .mem_rd(mem_rd), .mem_w_rd(mem_w_rd), .mem_bubble(mem_bubble), .mem_res(mem_res),
    .wb_rd(wb_rd), .wb_w_rd(wb_w_rd), .wb_res(wb_res),
    .stall(stall), .out_pc(out_pc), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .out_w_rd(out_w_rd), .out_is_load(out_is_load), .out_bubble(out_bubble)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      $error("[TB] %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Clock one edge and leave time just past it for sampling and re-driving.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_w_rd = 0; id_is_load = 0; id_bubble = 1;
    flush = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    ex_rd = '0; ex_w_rd = 0; ex_is_load = 0; ex_bubble = 1; ex_res = '0;
    mem_rd = '0; mem_w_rd = 0; mem_bubble = 1; mem_res = '0;
    wb_rd = '0; wb_w_rd = 0; wb_res = '0;
  endtask

  task automatic setDecode(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic [4:0] rd);
    id_pc = pc; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_w_rd = 1; id_is_load = 0; id_bubble = 0;
  endtask

  // Youngest valid producer of the register wins; r0 is hard-wired zero.
  function automatic logic [31:0] refOperand(input logic [4:0] s);
    logic        valid [3];
    logic [4:0]  dest  [3];
    logic [31:0] value [3];
    valid[0] = !ex_bubble && ex_w_rd && !ex_is_load; dest[0] = ex_rd;  value[0] = ex_res;
    valid[1] = !mem_bubble && mem_w_rd;               dest[1] = mem_rd; value[1] = mem_res;
    valid[2] = wb_w_rd;                               dest[2] = wb_rd;  value[2] = wb_res;
    if (s == 0) return 32'h0;
    for (int age = 0; age < 3; age++)
      if (valid[age] && dest[age] == s) return value[age];
    return regs[s];
  endfunction

  function automatic logic refHazard();
    logic reads_load_dest;
    reads_load_dest = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
    return !id_bubble && !ex_bubble && ex_is_load && ex_w_rd && ex_rd != 0 && reads_load_dest;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_bubble"}, 32'(out_bubble), 32'd1);
    checkOutput({tag, "_w_rd"},   32'(out_w_rd),   32'd0);
    checkOutput({tag, "_a"},      out_a,           32'h0);
    checkOutput({tag, "_b"},      out_b,           32'h0);
    checkOutput({tag, "_pc"},     out_pc,          32'h0);
    checkOutput({tag, "_rd"},     32'(out_rd),     32'd0);
    checkOutput({tag, "_load"},   32'(out_is_load), 32'd0);
  endtask

  initial begin
    logic        exp_stall, exp_hazard, exp_rst, exp_flush, exp_bub;
    logic        exp_use1, exp_use2, exp_wrd, exp_load;
    logic [31:0] exp_a, exp_b, exp_pc;
    logic [4:0]  exp_rd;

    rst = 1;
    idleInputs();
    applyStimulus();
    applyStimulus();
    rst = 0;
    checkResetState("reset");
    checkOutput("reset_stall", 32'(stall), 32'd0);

    // Plain register read
    regs[3] = 32'h11;
    setDecode(32'h40, 5'd3, 1, 5'd0, 0, 5'd9);
    applyStimulus();
    checkOutput("rf_read_a", out_a, 32'h11);
    checkOutput("rf_read_bubble", 32'(out_bubble), 32'd0);
    checkOutput("rf_read_pc", out_pc, 32'h40);
    checkOutput("rf_read_w_rd", 32'(out_w_rd), 32'd1);

    // Forwarding priority EX > MEM > WB
    setDecode(32'h44, 5'd0, 0, 5'd5, 1, 5'd6);
    regs[5] = 32'h55;
    ex_bubble = 0; ex_w_rd = 1; ex_rd = 5; ex_res = 32'hAA;
    mem_bubble = 0; mem_w_rd = 1; mem_rd = 5; mem_res = 32'hBB;
    wb_w_rd = 1; wb_rd = 5; wb_res = 32'hCC;
    applyStimulus();
    checkOutput("fwd_ex", out_b, 32'hAA);
    ex_bubble = 1;
    applyStimulus();
    checkOutput("fwd_mem", out_b, 32'hBB);
    mem_w_rd = 0;
    applyStimulus();
    checkOutput("fwd_wb", out_b, 32'hCC);
    wb_w_rd = 0;
    applyStimulus();
    checkOutput("fwd_none", out_b, 32'h55);

    // Load-use: one bubble, then forward from MEM
    idleInputs();
    setDecode(32'h100, 5'd7, 1, 5'd0, 0, 5'd8);
    ex_bubble = 0; ex_w_rd = 1; ex_is_load = 1; ex_rd = 7; ex_res = 32'hDEAD;
    #1 checkOutput("lu_stall", 32'(stall), 32'd1);
    applyStimulus();
    checkOutput("lu_bubble", 32'(out_bubble), 32'd1);
    checkOutput("lu_w_rd", 32'(out_w_rd), 32'd0);
    ex_bubble = 1; ex_is_load = 0;
    mem_bubble = 0; mem_w_rd = 1; mem_rd = 7; mem_res = 32'h1234;
    #1 checkOutput("lu_stall_clear", 32'(stall), 32'd0);
    applyStimulus();
    checkOutput("lu_fwd_a", out_a, 32'h1234);
    checkOutput("lu_fwd_bubble", 32'(out_bubble), 32'd0);
    checkOutput("lu_fwd_pc", out_pc, 32'h100);

    // r0 never forwards and never stalls
    idleInputs();
    setDecode(32'h200, 5'd0, 1, 5'd0, 0, 5'd1);
    ex_bubble = 0; ex_w_rd = 1; ex_rd = 0; ex_res = 32'hFF;
    applyStimulus();
    checkOutput("r0_a", out_a, 32'h0);
    ex_is_load = 1;
    #1 checkOutput("r0_load_stall", 32'(stall), 32'd0);

    // Flush beats hazard; reset during a stall
    idleInputs();
    setDecode(32'h300, 5'd4, 0, 5'd4, 1, 5'd2);
    ex_bubble = 0; ex_w_rd = 1; ex_is_load = 1; ex_rd = 4;
    flush = 1;
    #1 checkOutput("flush_stall", 32'(stall), 32'd0);
    applyStimulus();
    checkOutput("flush_bubble", 32'(out_bubble), 32'd1);
    checkOutput("flush_w_rd", 32'(out_w_rd), 32'd0);
    flush = 0;
    #1 checkOutput("hz_stall", 32'(stall), 32'd1);
    rst = 1;
    applyStimulus();
    rst = 0;
    idleInputs();
    checkResetState("rst_in_stall");
    #1 checkOutput("rst_in_stall_stall", 32'(stall), 32'd0);

    // Randomized cycles against the reference model
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 15) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      id_pc      = $urandom;
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      id_rd      = 5'($urandom_range(0, 31));
      id_use_rs1 = 1'($urandom);
      id_use_rs2 = 1'($urandom);
      id_w_rd    = 1'($urandom);
      id_is_load = 1'($urandom);
      id_bubble  = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      ex_rd  = 5'($urandom_range(0, 3)); ex_w_rd = 1'($urandom);
      ex_is_load = 1'($urandom); ex_bubble = ($urandom_range(0, 3) == 0); ex_res = $urandom;
      mem_rd = 5'($urandom_range(0, 3)); mem_w_rd = 1'($urandom);
      mem_bubble = ($urandom_range(0, 3) == 0); mem_res = $urandom;
      wb_rd  = 5'($urandom_range(0, 3)); wb_w_rd = 1'($urandom); wb_res = $urandom;

      exp_hazard = refHazard();
      exp_stall  = exp_hazard && !flush;
      exp_rst    = rst;
      exp_flush  = flush;
      exp_a      = refOperand(id_rs1);
      exp_b      = refOperand(id_rs2);
      exp_pc     = id_pc;
      exp_rd     = id_rd;
      exp_use1   = id_use_rs1;
      exp_use2   = id_use_rs2;
      exp_bub    = id_bubble;
      exp_wrd    = id_w_rd && !id_bubble;
      exp_load   = id_is_load;
      #1 checkOutput("rnd_stall", 32'(stall), 32'(exp_stall));
      applyStimulus();
      if (exp_rst) begin
        checkOutput("rnd_rst_bubble", 32'(out_bubble), 32'd1);
        checkOutput("rnd_rst_a", out_a, 32'h0);
        checkOutput("rnd_rst_w_rd", 32'(out_w_rd), 32'd0);
      end else if (exp_flush || exp_hazard) begin
        checkOutput("rnd_kill_bubble", 32'(out_bubble), 32'd1);
        checkOutput("rnd_kill_w_rd", 32'(out_w_rd), 32'd0);
      end else begin
        checkOutput("rnd_bubble", 32'(out_bubble), 32'(exp_bub));
        checkOutput("rnd_w_rd", 32'(out_w_rd), 32'(exp_wrd));
        if (!exp_bub) begin
          checkOutput("rnd_pc", out_pc, exp_pc);
          checkOutput("rnd_rd", 32'(out_rd), 32'(exp_rd));
          checkOutput("rnd_load", 32'(out_is_load), 32'(exp_load));
          if (exp_use1) checkOutput("rnd_a", out_a, exp_a);
          if (exp_use2) checkOutput("rnd_b", out_b, exp_b);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
